hdmi_data_island_decoder: RTL and testbench

Receive-side counterpart of the HDMI data-island encoder. It accepts the per-pixel 4-bit nibbles of TMDS channels 0/1/2 after TERC4 decoding, plus the data-island-period flag. From these it reassembles 32-clock packets, checks BCH(32,24) header parity and BCH(64,56) subpacket parity, and presents complete packets. It also extracts Audio Clock Regeneration N/CTS and streams 16-bit L/R PCM samples from audio sample packets; it sits between the TMDS/TERC4 decode front end and the audio/infoframe consumers.

---
 rtl/hdmi_pkg.sv | 29 ++
 rtl/hdmi_bch8.sv | 42 ++++
 rtl/hdmi_data_island_decoder.sv | 238 +++++++++++++++++++++++
 tb/tb_hdmi_data_island_decoder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared constants, types and the BCH(.., ..) parity step for the HDMI data-island receive path.
package hdmi_pkg;

   // Packet type codes carried in HB0.
   localparam logic [7:0] PKT_ACR   = 8'h01;
   localparam logic [7:0] PKT_AUDIO = 8'h02;
   localparam logic [7:0] PKT_AVI   = 8'h82;
   localparam logic [7:0] PKT_AINFO = 8'h84;

   // Generator for the 8-bit BCH parity used by both header and subpackets.
   localparam logic [7:0] BCH_POLY = 8'hC1;

   // Slot layout of one 32-clock packet.
   localparam int HDR_BITS  = 24;
   localparam int SUB_SLOTS = 28;
   localparam int PKT_SLOTS = 32;

   // Audio sample emitter: idle, or walking the mask of present samples.
   typedef enum logic {
      ST_IDLE,
      ST_EMIT
   } emit_state_e;

   // One BCH step for a single data bit.
   function automatic logic [7:0] bch_step(input logic [7:0] code, input logic b);
      return {code[6:0], 1'b0} ^ ((code[7] ^ b) ? BCH_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/hdmi_bch8.sv
// BCH parity accumulator: steps over data bits, then shifts out the expected
// parity bits MSB-first so the caller can compare them against the received ones.
module hdmi_bch8
   import hdmi_pkg::*;
#(
   parameter int BITS_PER_CLK = 1
)
(
   input  logic                    i_pixclk,
   input  logic                    i_reset,
   input  logic                    i_clear,
   input  logic                    i_en,
   input  logic                    i_shift,
   input  logic [BITS_PER_CLK-1:0] i_bits,
   output logic [BITS_PER_CLK-1:0] o_par
);

   logic [7:0] code_q, code_d;

   // Data phase folds bits in (bit 0 first); parity phase exposes the next expected bits.
   always_comb begin
      // NOTE: default assignment first so every path drives code_d and no latch is inferred.
      code_d = code_q;
      if (i_en) begin
         code_d = i_clear ? 8'h00 : code_q;
         for (int i = 0; i < BITS_PER_CLK; i++) begin
            code_d = bch_step(code_d, i_bits[i]);
         end
      end else if (i_shift) begin
         code_d = code_q << BITS_PER_CLK;
      end
   end

   // Accumulator register.
   always_ff @(posedge i_pixclk or posedge i_reset) begin
      if (i_reset) code_q <= 8'h00;
      else         code_q <= code_d;
   end

   assign o_par = code_q[7 -: BITS_PER_CLK];

endmodule

// File: rtl/hdmi_data_island_decoder.sv
// Data-island packet receiver: reassembles 32-slot packets from TERC4 nibbles,
// checks header/subpacket BCH parity, extracts ACR N/CTS and streams audio samples.
module hdmi_data_island_decoder
   import hdmi_pkg::*;
#(
   parameter int ERR_CNT_W = 16
)
(
   input  logic                 i_pixclk,
   input  logic                 i_reset,
   input  logic                 i_data,
   input  logic [3:0]           i_d0,
   input  logic [3:0]           i_d1,
   input  logic [3:0]           i_d2,
   output logic                 o_hsync,
   output logic                 o_vsync,
   output logic                 o_pkt_valid,
   output logic [23:0]          o_pkt_hdr,
   output logic [223:0]         o_pkt_sub,
   output logic                 o_hdr_err,
   output logic [3:0]           o_sub_err,
   output logic [ERR_CNT_W-1:0] o_err_count,
   output logic [19:0]          o_acr_n,
   output logic [19:0]          o_acr_cts,
   output logic                 o_acr_valid,
   output logic [15:0]          o_audio_l,
   output logic [15:0]          o_audio_r,
   output logic                 o_audio_strobe
);

   localparam logic [4:0] HDR_END   = 5'(HDR_BITS);
   localparam logic [4:0] SUB_END   = 5'(SUB_SLOTS);
   localparam logic [4:0] LAST_SLOT = 5'(PKT_SLOTS - 1);

   logic                 data_q, data_d;
   logic [4:0]           slot_q, slot_d;
   logic [23:0]          hdr_q, hdr_d;
   logic [3:0][55:0]     sub_q, sub_d;
   logic                 hdr_err_q, hdr_err_d;
   logic [3:0]           sub_err_q, sub_err_d;
   logic                 hsync_q, hsync_d, vsync_q, vsync_d;
   logic                 pkt_valid_q, pkt_valid_d;
   logic [23:0]          pkt_hdr_q, pkt_hdr_d;
   logic [3:0][55:0]     pkt_sub_q, pkt_sub_d;
   logic                 pkt_hdr_err_q, pkt_hdr_err_d;
   logic [3:0]           pkt_sub_err_q, pkt_sub_err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [19:0]          acr_n_q, acr_n_d, acr_cts_q, acr_cts_d;
   logic                 acr_valid_q, acr_valid_d;
   logic [15:0]          audio_l_q, audio_l_d, audio_r_q, audio_r_d;
   logic                 audio_strobe_q, audio_strobe_d;
   logic [3:0]           mask_q, mask_d;
   emit_state_e          state_q, state_d;

   logic [4:0]           cur_slot;
   logic                 slot_first, pkt_done;
   logic                 hdr_en, hdr_shift, sub_en, sub_shift;
   logic                 hdr_par;
   logic [3:0][1:0]      sub_par;
   logic [3:0]           load_mask;
   logic                 found;

   // Slot of the sample on the inputs now: island start or a cleared first-clock flag resyncs to 0.
   assign cur_slot   = (!data_q || !i_d0[3]) ? 5'd0 : slot_q;
   assign slot_first = i_data && (cur_slot == 5'd0);
   assign pkt_done   = i_data && (cur_slot == LAST_SLOT);
   assign hdr_en     = i_data && (cur_slot < HDR_END);
   assign hdr_shift  = i_data && !(cur_slot < HDR_END);
   assign sub_en     = i_data && (cur_slot < SUB_END);
   assign sub_shift  = i_data && !(cur_slot < SUB_END);

   hdmi_bch8 #(.BITS_PER_CLK(1)) u_hdr_bch (
      .i_pixclk (i_pixclk),
      .i_reset  (i_reset),
      .i_clear  (slot_first),
      .i_en     (hdr_en),
      .i_shift  (hdr_shift),
      .i_bits   (i_d0[2]),
      .o_par    (hdr_par)
   );

   for (genvar k = 0; k < 4; k++) begin : g_sub_bch
      hdmi_bch8 #(.BITS_PER_CLK(2)) u_sub_bch (
         .i_pixclk (i_pixclk),
         .i_reset  (i_reset),
         .i_clear  (slot_first),
         .i_en     (sub_en),
         .i_shift  (sub_shift),
         .i_bits   ({i_d2[k], i_d1[k]}),
         .o_par    (sub_par[k])
      );
   end

   // Packet assembly, parity comparison, completion, ACR capture and error counting.
   always_comb begin
      data_d        = i_data;
      slot_d        = i_data ? cur_slot + 5'd1 : 5'd0;
      hdr_d         = hdr_q;
      sub_d         = sub_q;
      hdr_err_d     = hdr_err_q;
      sub_err_d     = sub_err_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      pkt_valid_d   = pkt_done;
      pkt_hdr_d     = pkt_hdr_q;
      pkt_sub_d     = pkt_sub_q;
      pkt_hdr_err_d = pkt_hdr_err_q;
      pkt_sub_err_d = pkt_sub_err_q;
      err_cnt_d     = err_cnt_q;
      acr_n_d       = acr_n_q;
      acr_cts_d     = acr_cts_q;
      acr_valid_d   = 1'b0;
      load_mask     = 4'b0000;

      if (i_data) begin
         hsync_d = i_d0[0];
         vsync_d = i_d0[1];
      end
      if (slot_first) begin
         hdr_err_d = 1'b0;
         sub_err_d = 4'b0000;
      end
      if (hdr_en) hdr_d = {i_d0[2], hdr_q[23:1]};
      if (hdr_shift && (i_d0[2] != hdr_par)) hdr_err_d = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (sub_en) sub_d[k] = {i_d2[k], i_d1[k], sub_q[k][55:2]};
         if (sub_shift && ({i_d1[k], i_d2[k]} != sub_par[k])) sub_err_d[k] = 1'b1;
      end

      if (pkt_done) begin
         pkt_hdr_d     = hdr_q;
         pkt_sub_d     = sub_q;
         pkt_hdr_err_d = hdr_err_d;
         pkt_sub_err_d = sub_err_d;
         if ((hdr_err_d || (|sub_err_d)) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
         if ((hdr_q[7:0] == PKT_ACR) && !hdr_err_d && !sub_err_d[0]) begin
            acr_cts_d   = {sub_q[0][11:8], sub_q[0][23:16], sub_q[0][31:24]};
            acr_n_d     = {sub_q[0][35:32], sub_q[0][47:40], sub_q[0][55:48]};
            acr_valid_d = 1'b1;
         end
         if ((hdr_q[7:0] == PKT_AUDIO) && !hdr_err_d) load_mask = hdr_q[11:8] & ~sub_err_d;
      end
   end

   // Audio emitter: one strobe per set mask bit, lowest index first, from the presented packet.
   always_comb begin
      state_d        = state_q;
      mask_d         = mask_q;
      audio_l_d      = audio_l_q;
      audio_r_d      = audio_r_q;
      audio_strobe_d = 1'b0;
      found          = 1'b0;
      if (state_q == ST_EMIT) begin
         for (int k = 0; k < 4; k++) begin
            if (!found && mask_q[k]) begin
               found          = 1'b1;
               audio_l_d      = pkt_sub_q[k][23:8];
               audio_r_d      = pkt_sub_q[k][47:32];
               audio_strobe_d = 1'b1;
               mask_d[k]      = 1'b0;
            end
         end
         if (mask_d == 4'b0000) state_d = ST_IDLE;
      end
      if (load_mask != 4'b0000) begin
         mask_d  = load_mask;
         state_d = ST_EMIT;
      end
   end

   // State registers; reset clears everything including partial packets and emission.
   always_ff @(posedge i_pixclk or posedge i_reset) begin
      if (i_reset) begin
         data_q         <= 1'b0;
         slot_q         <= 5'd0;
         hdr_q          <= '0;
         sub_q          <= '0;
         hdr_err_q      <= 1'b0;
         sub_err_q      <= '0;
         hsync_q        <= 1'b0;
         vsync_q        <= 1'b0;
         pkt_valid_q    <= 1'b0;
         pkt_hdr_q      <= '0;
         pkt_sub_q      <= '0;
         pkt_hdr_err_q  <= 1'b0;
         pkt_sub_err_q  <= '0;
         err_cnt_q      <= '0;
         acr_n_q        <= '0;
         acr_cts_q      <= '0;
         acr_valid_q    <= 1'b0;
         audio_l_q      <= '0;
         audio_r_q      <= '0;
         audio_strobe_q <= 1'b0;
         mask_q         <= '0;
         state_q        <= ST_IDLE;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of the others.
         data_q         <= data_d;
         slot_q         <= slot_d;
         hdr_q          <= hdr_d;
         sub_q          <= sub_d;
         hdr_err_q      <= hdr_err_d;
         sub_err_q      <= sub_err_d;
         hsync_q        <= hsync_d;
         vsync_q        <= vsync_d;
         pkt_valid_q    <= pkt_valid_d;
         pkt_hdr_q      <= pkt_hdr_d;
         pkt_sub_q      <= pkt_sub_d;
         pkt_hdr_err_q  <= pkt_hdr_err_d;
         pkt_sub_err_q  <= pkt_sub_err_d;
         err_cnt_q      <= err_cnt_d;
         acr_n_q        <= acr_n_d;
         acr_cts_q      <= acr_cts_d;
         acr_valid_q    <= acr_valid_d;
         audio_l_q      <= audio_l_d;
         audio_r_q      <= audio_r_d;
         audio_strobe_q <= audio_strobe_d;
         mask_q         <= mask_d;
         state_q        <= state_d;
      end
   end

   assign o_hsync        = hsync_q;
   assign o_vsync        = vsync_q;
   assign o_pkt_valid    = pkt_valid_q;
   assign o_pkt_hdr      = pkt_hdr_q;
   assign o_pkt_sub      = pkt_sub_q;
   assign o_hdr_err      = pkt_hdr_err_q;
   assign o_sub_err      = pkt_sub_err_q;
   assign o_err_count    = err_cnt_q;
   assign o_acr_n        = acr_n_q;
   assign o_acr_cts      = acr_cts_q;
   assign o_acr_valid    = acr_valid_q;
   assign o_audio_l      = audio_l_q;
   assign o_audio_r      = audio_r_q;
   assign o_audio_strobe = audio_strobe_q;

endmodule

// File: tb/tb_hdmi_data_island_decoder.sv
// Directed bench for the data-island decoder: a BCH encoder model builds packets,
// a negedge monitor records pulses, and each scenario task compares what it saw.
module tb_hdmi_data_island_decoder;

   localparam int ERR_CNT_W = 16;

   // SB6..SB0 for ACR N=0x01800, CTS=0x0BB80 and for N=0x02000, CTS=0x12345.
   localparam logic [55:0] ACR_SUB0    = 56'h00_18_00_80_BB_00_00;
   localparam logic [55:0] ACR_SUB_ALT = 56'h00_20_00_45_23_01_00;

   logic                 i_pixclk = 1'b0;
   logic                 i_reset;
   logic                 i_data;
   logic [3:0]           i_d0, i_d1, i_d2;
   logic                 o_hsync, o_vsync, o_pkt_valid, o_hdr_err, o_acr_valid, o_audio_strobe;
   logic [23:0]          o_pkt_hdr;
   logic [223:0]         o_pkt_sub;
   logic [3:0]           o_sub_err;
   logic [ERR_CNT_W-1:0] o_err_count;
   logic [19:0]          o_acr_n, o_acr_cts;
   logic [15:0]          o_audio_l, o_audio_r;

   hdmi_data_island_decoder #(.ERR_CNT_W(ERR_CNT_W)) dut (
      .i_pixclk       (i_pixclk),
      .i_reset        (i_reset),
      .i_data         (i_data),
      .i_d0           (i_d0),
      .i_d1           (i_d1),
      .i_d2           (i_d2),
      .o_hsync        (o_hsync),
      .o_vsync        (o_vsync),
      .o_pkt_valid    (o_pkt_valid),
      .o_pkt_hdr      (o_pkt_hdr),
      .o_pkt_sub      (o_pkt_sub),
      .o_hdr_err      (o_hdr_err),
      .o_sub_err      (o_sub_err),
      .o_err_count    (o_err_count),
      .o_acr_n        (o_acr_n),
      .o_acr_cts      (o_acr_cts),
      .o_acr_valid    (o_acr_valid),
      .o_audio_l      (o_audio_l),
      .o_audio_r      (o_audio_r),
      .o_audio_strobe (o_audio_strobe)
   );

   always #5 i_pixclk = ~i_pixclk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_cyc = 0;

   always @(posedge i_pixclk) cyc <= cyc + 1;

   // Pulse monitor.
   int          pv_cnt = 0, pv_cyc = 0, acr_cnt = 0, acr_cyc = 0;
   logic [23:0] pv_hdr;
   logic        pv_herr;
   logic [3:0]  pv_serr;
   logic [31:0] aud_q[$];
   int          aud_cyc_q[$];

   always @(negedge i_pixclk) begin
      if (o_pkt_valid) begin
         pv_cnt++;
         pv_cyc  = cyc;
         pv_hdr  = o_pkt_hdr;
         pv_herr = o_hdr_err;
         pv_serr = o_sub_err;
      end
      if (o_acr_valid) begin
         acr_cnt++;
         acr_cyc = cyc;
      end
      if (o_audio_strobe) begin
         aud_q.push_back({o_audio_l, o_audio_r});
         aud_cyc_q.push_back(cyc);
      end
   end

   // Reference BCH parity over the first n bits, bit 0 first.
   function automatic logic [7:0] bch_par(input logic [55:0] bits, input int n);
      logic [7:0] c;
      logic       fb;
      c = 8'h00;
      for (int i = 0; i < n; i++) begin
         fb = c[7] ^ bits[i];
         c  = {c[6:0], 1'b0};
         if (fb) c = c ^ 8'hC1;
      end
      return c;
   endfunction

   // Encoder model: drives nslots slots of a packet; optional header bit flip / subpacket parity corruption.
   task automatic send_packet(input logic [23:0] hdr, input logic [3:0][55:0] sub, input logic [1:0] sync,
                              input int hflip, input int scorrupt, input int nslots, input logic first_flag);
      logic [7:0]       hp;
      logic [3:0][7:0]  sp;
      logic [23:0]      htx;
      hp  = bch_par({32'd0, hdr}, 24);
      htx = hdr;
      if (hflip >= 0) htx[hflip] = ~htx[hflip];
      for (int k = 0; k < 4; k++) sp[k] = bch_par(sub[k], 56);
      if (scorrupt >= 0) sp[scorrupt][0] = ~sp[scorrupt][0];
      for (int s = 0; s < nslots; s++) begin
         @(negedge i_pixclk);
         i_data     = 1'b1;
         i_d0[1:0]  = sync;
         i_d0[3]    = (s == 0) ? first_flag : 1'b1;
         i_d0[2]    = (s < 24) ? htx[s] : hp[31-s];
         for (int k = 0; k < 4; k++) begin
            if (s < 28) begin
               i_d1[k] = sub[k][2*s];
               i_d2[k] = sub[k][2*s+1];
            end else begin
               i_d1[k] = sp[k][63-2*s];
               i_d2[k] = sp[k][62-2*s];
            end
         end
         last_cyc = cyc + 1;
      end
   endtask

   // Outside islands: sync bits toggled so holding behaviour is exercised.
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge i_pixclk);
         i_data = 1'b0;
         i_d0   = 4'b0011;
         i_d1   = 4'h0;
         i_d2   = 4'h0;
      end
   endtask

   task automatic test_reset;
      i_reset = 1'b1;
      i_data  = 1'b0;
      i_d0    = 4'h0;
      i_d1    = 4'h0;
      i_d2    = 4'h0;
      repeat (3) @(negedge i_pixclk);
      checks++;
      if ({o_pkt_valid, o_pkt_hdr, o_pkt_sub, o_hdr_err, o_sub_err, o_acr_n, o_acr_cts, o_acr_valid,
           o_audio_l, o_audio_r, o_audio_strobe, o_hsync, o_vsync} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got nonzero output, required all zero");
      end
      checks++;
      if (o_err_count !== '0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", o_err_count); end
      i_reset = 1'b0;
      idle(2);
   endtask

   task automatic test_acr;
      int pv0, a0;
      pv0 = pv_cnt; a0 = acr_cnt;
      aud_q.delete(); aud_cyc_q.delete();
      send_packet(24'h000001, {4{ACR_SUB0}}, 2'b01, -1, -1, 32, 1'b0);
      idle(8);
      checks++; if (pv_cnt - pv0 !== 1) begin errors++; $display("FAIL acr_pkt_count got %0d exp 1", pv_cnt - pv0); end
      checks++; if (pv_cyc !== last_cyc) begin errors++; $display("FAIL acr_pkt_latency got cyc %0d exp %0d", pv_cyc, last_cyc); end
      checks++; if (pv_hdr !== 24'h000001) begin errors++; $display("FAIL acr_hdr got %h exp 000001", pv_hdr); end
      checks++; if ({pv_herr, pv_serr} !== 5'b0) begin errors++; $display("FAIL acr_errflags got %b exp 00000", {pv_herr, pv_serr}); end
      checks++; if (acr_cnt - a0 !== 1 || acr_cyc !== last_cyc) begin errors++; $display("FAIL acr_valid got %0d pulses at %0d exp 1 at %0d", acr_cnt - a0, acr_cyc, last_cyc); end
      checks++; if (o_acr_n !== 20'h01800) begin errors++; $display("FAIL acr_n got %h exp 01800", o_acr_n); end
      checks++; if (o_acr_cts !== 20'h0BB80) begin errors++; $display("FAIL acr_cts got %h exp 0bb80", o_acr_cts); end
      checks++; if (o_err_count !== 0) begin errors++; $display("FAIL acr_err_count got %0d exp 0", o_err_count); end
      checks++; if (aud_q.size() !== 0) begin errors++; $display("FAIL acr_no_audio got %0d strobes exp 0", aud_q.size()); end
      checks++; if ({o_hsync, o_vsync} !== 2'b10) begin errors++; $display("FAIL sync_hold got h%b v%b exp h1 v0", o_hsync, o_vsync); end
   endtask

   task automatic test_audio;
      int pv0, a0;
      pv0 = pv_cnt; a0 = acr_cnt;
      aud_q.delete(); aud_cyc_q.delete();
      send_packet(24'h000302, {56'h11_2222_33_4444_55, 56'h66_7777_88_9999_AA,
                               56'h00_AAAA_00_5555_00, 56'h00_ABCD_00_1234_00}, 2'b10, -1, -1, 32, 1'b0);
      idle(8);
      checks++; if (pv_cnt - pv0 !== 1 || pv_hdr !== 24'h000302) begin errors++; $display("FAIL audio_pkt got %0d pkts hdr %h exp 1 hdr 000302", pv_cnt - pv0, pv_hdr); end
      checks++; if ({pv_herr, pv_serr} !== 5'b0) begin errors++; $display("FAIL audio_errflags got %b exp 00000", {pv_herr, pv_serr}); end
      checks++; if (aud_q.size() !== 2) begin errors++; $display("FAIL audio_strobe_count got %0d exp 2", aud_q.size()); end
      if (aud_q.size() >= 2) begin
         checks++; if (aud_q[0] !== 32'h1234ABCD || aud_cyc_q[0] !== last_cyc + 1) begin errors++; $display("FAIL audio_s0 got %h at %0d exp 1234abcd at %0d", aud_q[0], aud_cyc_q[0], last_cyc + 1); end
         checks++; if (aud_q[1] !== 32'h5555AAAA || aud_cyc_q[1] !== last_cyc + 2) begin errors++; $display("FAIL audio_s1 got %h at %0d exp 5555aaaa at %0d", aud_q[1], aud_cyc_q[1], last_cyc + 2); end
      end
      checks++; if (acr_cnt !== a0) begin errors++; $display("FAIL audio_no_acr got %0d pulses exp 0", acr_cnt - a0); end
      checks++; if ({o_hsync, o_vsync} !== 2'b01) begin errors++; $display("FAIL audio_sync got h%b v%b exp h0 v1", o_hsync, o_vsync); end
   endtask

   task automatic test_hdr_err;
      int pv0, a0;
      pv0 = pv_cnt; a0 = acr_cnt;
      send_packet(24'h000001, {4{ACR_SUB_ALT}}, 2'b00, 5, -1, 32, 1'b0);
      idle(8);
      checks++; if (pv_cnt - pv0 !== 1 || pv_hdr !== 24'h000021) begin errors++; $display("FAIL hdrerr_pkt got %0d pkts hdr %h exp 1 hdr 000021", pv_cnt - pv0, pv_hdr); end
      checks++; if ({pv_herr, pv_serr} !== 5'b10000) begin errors++; $display("FAIL hdrerr_flags got %b exp 10000", {pv_herr, pv_serr}); end
      checks++; if (acr_cnt !== a0 || o_acr_n !== 20'h01800 || o_acr_cts !== 20'h0BB80) begin errors++; $display("FAIL hdrerr_acr_hold got n %h cts %h exp n 01800 cts 0bb80", o_acr_n, o_acr_cts); end
      checks++; if (o_err_count !== 1) begin errors++; $display("FAIL hdrerr_err_count got %0d exp 1", o_err_count); end
      // ACR whose subpacket 0 parity is bad must not update N/CTS either.
      send_packet(24'h000001, {4{ACR_SUB_ALT}}, 2'b00, -1, 0, 32, 1'b0);
      idle(8);
      checks++; if ({pv_herr, pv_serr} !== 5'b00001) begin errors++; $display("FAIL sub0err_flags got %b exp 00001", {pv_herr, pv_serr}); end
      checks++; if (acr_cnt !== a0 || o_acr_n !== 20'h01800) begin errors++; $display("FAIL sub0err_acr_hold got n %h exp 01800", o_acr_n); end
      checks++; if (o_err_count !== 2) begin errors++; $display("FAIL sub0err_err_count got %0d exp 2", o_err_count); end
   endtask

   task automatic test_sub_err;
      aud_q.delete(); aud_cyc_q.delete();
      send_packet(24'h000F02, {56'h00_8888_00_7777_00, 56'h00_A5A5_00_5A5A_00,
                               56'h00_4444_00_3333_00, 56'h00_2222_00_1111_00}, 2'b00, -1, 2, 32, 1'b0);
      idle(8);
      checks++; if ({pv_herr, pv_serr} !== 5'b00100) begin errors++; $display("FAIL suberr_flags got %b exp 00100", {pv_herr, pv_serr}); end
      checks++; if (aud_q.size() !== 3) begin errors++; $display("FAIL suberr_strobe_count got %0d exp 3", aud_q.size()); end
      if (aud_q.size() >= 3) begin
         checks++; if (aud_q[0] !== 32'h11112222 || aud_cyc_q[0] !== last_cyc + 1) begin errors++; $display("FAIL suberr_s0 got %h at %0d exp 11112222 at %0d", aud_q[0], aud_cyc_q[0], last_cyc + 1); end
         checks++; if (aud_q[1] !== 32'h33334444 || aud_cyc_q[1] !== last_cyc + 2) begin errors++; $display("FAIL suberr_s1 got %h at %0d exp 33334444 at %0d", aud_q[1], aud_cyc_q[1], last_cyc + 2); end
         checks++; if (aud_q[2] !== 32'h77778888 || aud_cyc_q[2] !== last_cyc + 3) begin errors++; $display("FAIL suberr_s3 got %h at %0d exp 77778888 at %0d", aud_q[2], aud_cyc_q[2], last_cyc + 3); end
      end
      checks++; if (o_err_count !== 3) begin errors++; $display("FAIL suberr_err_count got %0d exp 3", o_err_count); end
   endtask

   task automatic test_drop_and_resync;
      int pv0, a0;
      pv0 = pv_cnt; a0 = acr_cnt;
      aud_q.delete(); aud_cyc_q.delete();
      // Island ends at slot 15; the next island's first slot has its flag set, so only the island edge resyncs.
      send_packet(24'h000001, {4{ACR_SUB_ALT}}, 2'b00, -1, -1, 15, 1'b0);
      idle(4);
      send_packet(24'h0D0282, {56'h0, 56'h0, 56'h0, 56'h00_00_00_00_18_40_5C}, 2'b00, -1, -1, 32, 1'b1);
      idle(8);
      checks++; if (pv_cnt - pv0 !== 1 || pv_hdr !== 24'h0D0282) begin errors++; $display("FAIL drop_pkt got %0d pkts hdr %h exp 1 hdr 0d0282", pv_cnt - pv0, pv_hdr); end
      checks++; if ({pv_herr, pv_serr} !== 5'b0 || o_err_count !== 3) begin errors++; $display("FAIL drop_errors got %b cnt %0d exp 00000 cnt 3", {pv_herr, pv_serr}, o_err_count); end
      checks++; if (acr_cnt !== a0 || o_acr_n !== 20'h01800) begin errors++; $display("FAIL drop_no_acr got n %h exp 01800", o_acr_n); end
      // Partial audio packet then, without leaving the island, a fresh packet with the first-clock flag cleared.
      pv0 = pv_cnt;
      send_packet(24'h000302, {4{56'h00_1111_00_2222_00}}, 2'b00, -1, -1, 10, 1'b0);
      send_packet(24'h0A0184, {56'h0, 56'h0, 56'h0, 56'h00_00_00_00_00_01_70}, 2'b00, -1, -1, 32, 1'b0);
      idle(8);
      checks++; if (pv_cnt - pv0 !== 1 || pv_hdr !== 24'h0A0184) begin errors++; $display("FAIL resync_pkt got %0d pkts hdr %h exp 1 hdr 0a0184", pv_cnt - pv0, pv_hdr); end
      checks++; if ({pv_herr, pv_serr} !== 5'b0 || aud_q.size() !== 0) begin errors++; $display("FAIL resync_clean got flags %b strobes %0d exp 00000 0", {pv_herr, pv_serr}, aud_q.size()); end
   endtask

   task automatic test_reset_mid;
      int pv0;
      send_packet(24'h000001, {4{ACR_SUB0}}, 2'b11, -1, -1, 20, 1'b0);
      @(posedge i_pixclk);
      #2 i_reset = 1'b1;
      #1;
      checks++;
      if ({o_pkt_valid, o_pkt_hdr, o_pkt_sub, o_hdr_err, o_sub_err, o_acr_n, o_acr_cts, o_acr_valid,
           o_audio_l, o_audio_r, o_audio_strobe, o_hsync, o_vsync} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got nonzero output, required all zero");
      end
      checks++; if (o_err_count !== '0) begin errors++; $display("FAIL midreset_err_count got %0d exp 0", o_err_count); end
      @(negedge i_pixclk);
      i_reset = 1'b0;
      i_data  = 1'b0;
      idle(2);
      pv0 = pv_cnt;
      send_packet(24'h000001, {4{ACR_SUB_ALT}}, 2'b00, -1, -1, 32, 1'b0);
      idle(8);
      checks++; if (pv_cnt - pv0 !== 1 || pv_cyc !== last_cyc || {pv_herr, pv_serr} !== 5'b0) begin errors++; $display("FAIL postreset_pkt got %0d pkts at %0d flags %b exp 1 at %0d flags 00000", pv_cnt - pv0, pv_cyc, {pv_herr, pv_serr}, last_cyc); end
      checks++; if (o_acr_n !== 20'h02000 || o_acr_cts !== 20'h12345) begin errors++; $display("FAIL postreset_acr got n %h cts %h exp n 02000 cts 12345", o_acr_n, o_acr_cts); end
      checks++; if (o_err_count !== 0) begin errors++; $display("FAIL postreset_err_count got %0d exp 0", o_err_count); end
   endtask

   initial begin
      test_reset();
      test_acr();
      test_audio();
      test_hdr_err();
      test_sub_err();
      test_drop_and_resync();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
